mcu_link_arbiter: RTL and testbench

// - Shares the single MCU byte link (SPI slave side) between NUM_TGT byte-stream targets (hid, osd, sdc, ...).
// - First byte of a frame selects the target; later bytes are forwarded to it; its reply byte is muxed back.
// - Collects target interrupt requests into one MCU irq; the MCU reads and acks them via the built-in system target.

---
 rtl/mcu_link_arbiter_pkg.sv | 23 ++
 rtl/mcu_irq_collector.sv | 66 ++++++
 rtl/mcu_link_arbiter.sv | 143 ++++++++++++++
 tb/tb_mcu_link_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_link_arbiter_pkg.sv
// Shared definitions for the MCU byte-link arbiter: FSM states, system target ids and commands.
// Used by mcu_link_arbiter and mcu_irq_collector.
package mcu_link_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCmd     = 2'd1,
        StBody    = 2'd2,
        StDiscard = 2'd3
    } link_state_e;

    localparam logic [7:0] SYS_ID_DEFAULT   = 8'h00;
    localparam logic [7:0] SYS_CMD_CORE_ID  = 8'h00;
    localparam logic [7:0] SYS_CMD_IRQ_READ = 8'h01;
    localparam logic [7:0] SYS_CMD_IRQ_MASK = 8'h02;

    // System id takes precedence if it overlaps the external range.
    function automatic logic is_ext_id(input logic [7:0] id, input logic [7:0] sys_id,
                                       input logic [7:0] num_tgt);
        return (id != sys_id) && (id != 8'h00) && (id <= num_tgt);
    endfunction

endpackage

// File: rtl/mcu_irq_collector.sv
// Interrupt collector: rising-edge detect, pending latch, ack pulses, masked irq output.
// MCU_LINK_IRQ_MASK_EN adds a writable mask; otherwise the mask is all ones.
module mcu_irq_collector
    import mcu_link_arbiter_pkg::*;
#(
    parameter int unsigned NUM_TGT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_TGT-1:0] tgt_irq,
    input  logic               ack_req,
    input  logic               mask_wr,
    input  logic [NUM_TGT-1:0] mask_din,
    output logic [NUM_TGT-1:0] pending,
    output logic               irq,
    output logic [NUM_TGT-1:0] tgt_iack
);

    logic [NUM_TGT-1:0] irq_prev_q;
    logic [NUM_TGT-1:0] pending_q, pending_d;
    logic [NUM_TGT-1:0] iack_q;
    logic [NUM_TGT-1:0] mask;
    logic               irq_q;

`ifdef MCU_LINK_IRQ_MASK_EN
    logic [NUM_TGT-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '1;
        end else if (mask_wr) begin
            mask_q <= mask_din;
        end
    end

    assign mask = mask_q;
`else
    logic unused_mask;
    assign unused_mask = ^{mask_wr, mask_din};
    assign mask        = '1;
`endif

    // A new edge in the ack cycle must survive the clear.
    always_comb begin
        pending_d = (pending_q & ~iack_q) | (tgt_irq & ~irq_prev_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            iack_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_prev_q <= tgt_irq;
            pending_q  <= pending_d;
            iack_q     <= ack_req ? pending_q : '0;
            irq_q      <= |(pending_q & mask);
        end
    end

    assign pending  = pending_q;
    assign irq      = irq_q;
    assign tgt_iack = iack_q;

endmodule

// File: rtl/mcu_link_arbiter.sv
// Shares the MCU SPI byte link among NUM_TGT byte-stream targets plus a built-in system target.
// MCU_LINK_IRQ_MASK_EN enables system command 0x02 (irq mask write).
module mcu_link_arbiter
    import mcu_link_arbiter_pkg::*;
#(
    parameter int unsigned NUM_TGT = 4,
    parameter logic [7:0]  SYS_ID  = SYS_ID_DEFAULT,
    parameter logic [7:0]  CORE_ID = 8'h5c
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_strobe,
    input  logic                 spi_start,
    input  logic [7:0]           spi_din,
    output logic [7:0]           spi_dout,
    output logic                 irq,
    output logic [NUM_TGT-1:0]   tgt_strobe,
    output logic                 tgt_start,
    output logic [7:0]           tgt_din,
    input  logic [8*NUM_TGT-1:0] tgt_dout,
    input  logic [NUM_TGT-1:0]   tgt_irq,
    output logic [NUM_TGT-1:0]   tgt_iack
);

    localparam logic [7:0] NumTgtId = 8'(NUM_TGT);

    link_state_e        state_q, state_d;
    logic [7:0]         id_q, id_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         reply_q, reply_d;
    logic [7:0]         tgt_din_q, tgt_din_d;
    logic [NUM_TGT-1:0] tgt_strobe_q, tgt_strobe_d;
    logic               tgt_start_q, tgt_start_d;
    logic               ack_req, mask_wr;
    logic [NUM_TGT-1:0] pending;
    logic               cur_sys, in_frame;
    logic [7:0]         ext_dout;

    assign cur_sys  = (id_q == SYS_ID);
    assign in_frame = (state_q == StCmd) || (state_q == StBody);
    assign ext_dout = 8'(tgt_dout >> {id_q - 8'd1, 3'b000});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        if (spi_strobe) begin
            if (spi_start) begin
                id_d    = spi_din;
                state_d = ((spi_din == SYS_ID) || is_ext_id(spi_din, SYS_ID, NumTgtId)) ?
                          StCmd : StDiscard;
            end else if (state_q == StCmd) begin
                state_d = StBody;
            end
        end
    end

    always_comb begin
        tgt_strobe_d = '0;
        tgt_start_d  = 1'b0;
        tgt_din_d    = tgt_din_q;
        cmd_d        = cmd_q;
        reply_d      = reply_q;
        ack_req      = 1'b0;
        mask_wr      = 1'b0;
        if (spi_strobe && !spi_start && in_frame) begin
            if (!cur_sys) begin
                tgt_strobe_d = NUM_TGT'(1) << (id_q - 8'd1);
                tgt_start_d  = (state_q == StCmd);
                tgt_din_d    = spi_din;
            end else if (state_q == StCmd) begin
                cmd_d = spi_din;
                case (spi_din)
                    SYS_CMD_CORE_ID:  reply_d = CORE_ID;
                    SYS_CMD_IRQ_READ: begin
                        reply_d = 8'(pending);
                        ack_req = 1'b1;
                    end
                    default:          reply_d = 8'h00;
                endcase
            end
`ifdef MCU_LINK_IRQ_MASK_EN
            else if (cmd_q == SYS_CMD_IRQ_MASK) begin
                mask_wr = 1'b1;
            end
`endif
        end

        unique case (state_q)
            StCmd, StBody: spi_dout = cur_sys ? reply_q : ext_dout;
            default:       spi_dout = 8'h00;
        endcase
    end

`ifndef MCU_LINK_IRQ_MASK_EN
    logic unused_cmd;
    assign unused_cmd = ^cmd_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            id_q         <= 8'h00;
            cmd_q        <= 8'h00;
            reply_q      <= 8'h00;
            tgt_din_q    <= 8'h00;
            tgt_strobe_q <= '0;
            tgt_start_q  <= 1'b0;
        end else begin
            id_q         <= id_d;
            cmd_q        <= cmd_d;
            reply_q      <= reply_d;
            tgt_din_q    <= tgt_din_d;
            tgt_strobe_q <= tgt_strobe_d;
            tgt_start_q  <= tgt_start_d;
        end
    end

    assign tgt_strobe = tgt_strobe_q;
    assign tgt_start  = tgt_start_q;
    assign tgt_din    = tgt_din_q;

    mcu_irq_collector #(
        .NUM_TGT (NUM_TGT)
    ) u_irq (
        .clk      (clk),
        .reset    (reset),
        .tgt_irq  (tgt_irq),
        .ack_req  (ack_req),
        .mask_wr  (mask_wr),
        .mask_din (NUM_TGT'(spi_din)),
        .pending  (pending),
        .irq      (irq),
        .tgt_iack (tgt_iack)
    );

endmodule

// File: tb/tb_mcu_link_arbiter.sv
// Directed bench for mcu_link_arbiter (NUM_TGT=4); forwarded bytes checked against a scoreboard.
// Covers the MCU_LINK_IRQ_MASK_EN build when that macro is defined.
module tb_mcu_link_arbiter;

    typedef struct packed {
        logic [3:0]  strobe;
        logic        start;
        logic [7:0]  din;
        logic [31:0] due;
    } fwd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_strobe, spi_start;
    logic [7:0]  spi_din, spi_dout;
    logic        irq;
    logic [3:0]  tgt_strobe;
    logic        tgt_start;
    logic [7:0]  tgt_din;
    logic [31:0] tgt_dout;
    logic [3:0]  tgt_irq;
    logic [3:0]  tgt_iack;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] cyc      = 0;
    fwd_t        exp_q[$];

    mcu_link_arbiter #(
        .NUM_TGT (4),
        .SYS_ID  (8'h00),
        .CORE_ID (8'h5c)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_strobe (spi_strobe),
        .spi_start  (spi_start),
        .spi_din    (spi_din),
        .spi_dout   (spi_dout),
        .irq        (irq),
        .tgt_strobe (tgt_strobe),
        .tgt_start  (tgt_start),
        .tgt_din    (tgt_din),
        .tgt_dout   (tgt_dout),
        .tgt_irq    (tgt_irq),
        .tgt_iack   (tgt_iack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // fwd != 0 means the byte must reach that one-hot target one cycle later.
    task automatic send_byte(input logic start, input logic [7:0] din, input logic [3:0] fwd,
                             input logic fwd_start);
        fwd_t e;
        @(negedge clk);
        spi_strobe = 1'b1;
        spi_start  = start;
        spi_din    = din;
        if (fwd != 4'd0) begin
            e.strobe = fwd;
            e.start  = fwd_start;
            e.din    = din;
            e.due    = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        spi_strobe = 1'b0;
        spi_start  = 1'b0;
    endtask

    always @(negedge clk) begin
        fwd_t e;
        if (tgt_strobe != 4'd0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {27'd0, tgt_strobe, tgt_start}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("fwd_data", {19'd0, tgt_strobe, tgt_start, tgt_din},
                      {19'd0, e.strobe, e.start, e.din});
                check("fwd_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        spi_strobe = 1'b0;
        spi_start  = 1'b0;
        spi_din    = 8'h00;
        tgt_irq    = 4'd0;
        tgt_dout   = {8'h99, 8'h11, 8'hA7, 8'h3C};
        repeat (2) @(negedge clk);
        check("rst_dout", {24'd0, spi_dout}, 32'h00);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_strobe", {28'd0, tgt_strobe}, 32'd0);
        check("rst_start", {31'd0, tgt_start}, 32'd0);
        check("rst_din", {24'd0, tgt_din}, 32'h00);
        check("rst_iack", {28'd0, tgt_iack}, 32'd0);
        reset = 1'b0;

        // Frame to target0
        send_byte(1'b1, 8'h01, 4'b0000, 1'b0);
        check("t0_cmd_dout", {24'd0, spi_dout}, 32'h3C);
        send_byte(1'b0, 8'h02, 4'b0001, 1'b1);
        send_byte(1'b0, 8'h05, 4'b0001, 1'b0);
        send_byte(1'b0, 8'hFB, 4'b0001, 1'b0);
        send_byte(1'b0, 8'h00, 4'b0001, 1'b0);
        check("t0_body_dout", {24'd0, spi_dout}, 32'h3C);

        // Reply mux for target1, then an out-of-range id
        send_byte(1'b1, 8'h02, 4'b0000, 1'b0);
        check("t1_cmd_dout", {24'd0, spi_dout}, 32'hA7);
        send_byte(1'b0, 8'h33, 4'b0010, 1'b1);
        check("t1_body_dout", {24'd0, spi_dout}, 32'hA7);
        send_byte(1'b1, 8'h09, 4'b0000, 1'b0);
        check("discard_dout", {24'd0, spi_dout}, 32'h00);
        send_byte(1'b0, 8'h44, 4'b0000, 1'b0);
        check("discard_body_dout", {24'd0, spi_dout}, 32'h00);

        // Interrupt from target2: raise, read, ack, no retrigger while held
        @(negedge clk);
        tgt_irq[2] = 1'b1;
        @(negedge clk);
        check("irq2_early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq2_raised", {31'd0, irq}, 32'd1);
        send_byte(1'b1, 8'h00, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h01, 4'b0000, 1'b0);
        check("irq_read_04", {24'd0, spi_dout}, 32'h04);
        check("iack2_pulse", {28'd0, tgt_iack}, 32'h4);
        @(negedge clk);
        check("iack2_done", {28'd0, tgt_iack}, 32'h0);
        check("irq2_lag", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq2_cleared", {31'd0, irq}, 32'd0);
        repeat (5) @(negedge clk);
        check("irq2_held_no_retrig", {31'd0, irq}, 32'd0);
        send_byte(1'b1, 8'h00, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h01, 4'b0000, 1'b0);
        check("irq_read_empty", {24'd0, spi_dout}, 32'h00);
        check("iack_none", {28'd0, tgt_iack}, 32'h0);

        // New edge on bit1 during its own ack cycle
        tgt_irq[1] = 1'b1;
        repeat (2) @(negedge clk);
        check("irq1_raised", {31'd0, irq}, 32'd1);
        tgt_irq[1] = 1'b0;
        send_byte(1'b1, 8'h00, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h01, 4'b0000, 1'b0);
        check("irq_read_02", {24'd0, spi_dout}, 32'h02);
        check("iack1_pulse", {28'd0, tgt_iack}, 32'h2);
        tgt_irq[1] = 1'b1;
        @(negedge clk);
        check("irq1_kept_a", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq1_kept_b", {31'd0, irq}, 32'd1);
        send_byte(1'b1, 8'h00, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h01, 4'b0000, 1'b0);
        check("irq1_still_pending", {24'd0, spi_dout}, 32'h02);
        tgt_irq = 4'd0;
        repeat (3) @(negedge clk);
        check("irq1_cleared", {31'd0, irq}, 32'd0);

        // Start byte aborts a running frame
        send_byte(1'b1, 8'h01, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h10, 4'b0001, 1'b1);
        send_byte(1'b1, 8'h03, 4'b0000, 1'b0);
        check("t2_cmd_dout", {24'd0, spi_dout}, 32'h11);
        send_byte(1'b0, 8'h20, 4'b0100, 1'b1);
        send_byte(1'b0, 8'h21, 4'b0100, 1'b0);

        // Reset mid-frame drops the strobe in the reset cycle
        send_byte(1'b1, 8'h04, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h55, 4'b1000, 1'b1);
        reset      = 1'b1;
        spi_strobe = 1'b1;
        spi_din    = 8'h66;
        @(negedge clk);
        spi_strobe = 1'b0;
        check("mrst_dout", {24'd0, spi_dout}, 32'h00);
        check("mrst_strobe", {28'd0, tgt_strobe}, 32'd0);
        check("mrst_start", {31'd0, tgt_start}, 32'd0);
        check("mrst_din", {24'd0, tgt_din}, 32'h00);
        check("mrst_irq", {31'd0, irq}, 32'd0);
        check("mrst_iack", {28'd0, tgt_iack}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send_byte(1'b0, 8'h77, 4'b0000, 1'b0);
        check("idle_ignored_dout", {24'd0, spi_dout}, 32'h00);

        // Core id and unknown command
        send_byte(1'b1, 8'h00, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h00, 4'b0000, 1'b0);
        check("core_id", {24'd0, spi_dout}, 32'h5C);
        send_byte(1'b1, 8'h00, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h07, 4'b0000, 1'b0);
        check("unknown_cmd", {24'd0, spi_dout}, 32'h00);
        send_byte(1'b0, 8'hAB, 4'b0000, 1'b0);
        check("unknown_payload", {24'd0, spi_dout}, 32'h00);

        // Mask command
        send_byte(1'b1, 8'h00, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h02, 4'b0000, 1'b0);
        check("mask_cmd_reply", {24'd0, spi_dout}, 32'h00);
        send_byte(1'b0, 8'hFE, 4'b0000, 1'b0);
        check("mask_payload_reply", {24'd0, spi_dout}, 32'h00);
        @(negedge clk);
        tgt_irq[0] = 1'b1;
        repeat (3) @(negedge clk);
`ifdef MCU_LINK_IRQ_MASK_EN
        check("irq0_masked", {31'd0, irq}, 32'd0);
`else
        check("irq0_unmasked", {31'd0, irq}, 32'd1);
`endif
        send_byte(1'b1, 8'h00, 4'b0000, 1'b0);
        send_byte(1'b0, 8'h01, 4'b0000, 1'b0);
        check("irq_read_01", {24'd0, spi_dout}, 32'h01);
        check("iack0_pulse", {28'd0, tgt_iack}, 32'h1);
        tgt_irq = 4'd0;
        repeat (4) @(negedge clk);
        check("irq_final", {31'd0, irq}, 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
